ysyx_22040237_dmem_rsp: RTL and testbench
=========================================

YSYX_22040237_DMEM_RSP -- requirements
Module: ysyx_22040237_dmem_rsp

Interface
REQ-001 Parameter BASE, default 64'h8000_0000: byte address of word 0.
REQ-002 Parameter DEPTH, default 256: number of 64-bit words; power of two, 2 to 4096.
REQ-003 Parameter LAT, default 2: cycles from request accept to rsp_valid; 1 to 15.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  LSU request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_wen  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  64  byte address.
REQ-010 req_wdata  input  64  store data, little-endian lanes.
REQ-011 req_wmask  input  8  store byte-lane enables; bit i covers wdata[8i+7:8i].
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  LSU accepts response.
REQ-014 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  request faulted; no memory side effect.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Accept = req_valid & req_ready; on accept, the block SHALL latch wen/addr/wdata/wmask and go to WAIT with counter = LAT-1, or go straight to RESP when LAT=1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL move to RESP, so rsp_valid rises exactly LAT cycles after the accept edge.
REQ-019 Word index SHALL be (addr-BASE)>>3, computed mod 2^64; index >= DEPTH (including addr < BASE, by wrap) SHALL set rsp_err=1.
REQ-020 A store SHALL write only the masked lanes, on the edge entering RESP; wmask=0 SHALL be a legal no-op store with err=0.
REQ-021 A load SHALL capture the full 64-bit word on the edge entering RESP; rsp_rdata SHALL stay stable while in RESP.
REQ-022 In RESP, rsp_valid SHALL be 1 and SHALL hold with stable rdata/err until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-023 A request SHALL NOT be accepted in the same cycle a response completes (no bypass); at most one request is outstanding.
REQ-024 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-025 While rst=1: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 Reset in WAIT SHALL drop the pending request without writing memory; reset in RESP SHALL drop the response (the store is already committed).
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 Macro YSYX_22040237_DMEM_MISALIGN_CHK_EN defined: a request with req_addr[2:0] != 0 SHALL respond rsp_err=1, with no write and rdata=0, after the normal LAT.
REQ-029 Macro undefined: req_addr[2:0] SHALL be ignored; the access targets the containing aligned word.

Verification
REQ-030 LAT=2: store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF; then load the same address -> rsp_valid 2 cycles after each accept, rdata 0x1122334455667788, err=0.
REQ-031 Store wmask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over word 0x1122334455667788 -> later load returns 0x11223344_BBBBBBBB.
REQ-032 Load addr 0x7FFF_FFF8 and load addr BASE+DEPTH*8 -> err=1, rdata=0, memory unchanged.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, new req_valid ignored; accept resumes the cycle after the response handshake.
REQ-034 Assert rst one cycle after a store accept (LAT=3) -> outputs at reset values; later load of that word shows the old value.
REQ-035 Macro defined, load addr 0x8000_0004 -> err=1; macro undefined -> returns word at 0x8000_0000, err=0.

Source files
------------

// File: rtl/ysyx_22040237_dmem_rsp.sv
// ysyx_22040237_dmem_rsp: fixed-latency LSU data-memory responder; define YSYX_22040237_DMEM_MISALIGN_CHK_EN to fault misaligned addresses
module ysyx_22040237_dmem_rsp #(
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int DEPTH = 256,
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wen_q, wen_d, err_q, err_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] wmask_q, wmask_d;
  logic [63:0] mem [DEPTH];
  logic accept, enter, a_wen, a_err, unused_ok;
  logic [63:0] a_addr, a_wdata, off;
  logic [7:0] a_wmask;
  logic [AW-1:0] idx;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  assign accept = req_valid & req_ready;
  // With LAT=1 RESP is entered on the accept edge itself, so the live request is used while idle.
  assign a_wen = req_ready ? req_wen : wen_q;
  assign a_addr = req_ready ? req_addr : addr_q;
  assign a_wdata = req_ready ? req_wdata : wdata_q;
  assign a_wmask = req_ready ? req_wmask : wmask_q;
  assign off = a_addr - BASE;
  assign idx = off[AW+2:3];
  assign unused_ok = ^off[2:0];
`ifdef YSYX_22040237_DMEM_MISALIGN_CHK_EN
  assign a_err = (|off[63:AW+3]) | (|a_addr[2:0]);
`else
  assign a_err = |off[63:AW+3];
`endif
  // Next-state, request latch and response capture on the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d = err_q;
    enter = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        wen_d = req_wen;
        addr_d = req_addr;
        wdata_d = req_wdata;
        wmask_d = req_wmask;
        state_d = LAT == 1 ? RESP : WAIT;
        cnt_d = LAT == 1 ? 4'd0 : 4'(LAT - 1);
        enter = LAT == 1;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_d == 4'd0 ? RESP : WAIT;
        enter = cnt_d == 4'd0;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (enter) begin
      err_d = a_err;
      rdata_d = (a_err | a_wen) ? 64'd0 : mem[idx];
    end
  end
  // State and response registers; a reset drops whatever is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      wen_q <= 1'b0;
      addr_q <= 64'd0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      rdata_q <= 64'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  // Byte-masked store commit on the edge entering RESP; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (enter & a_wen & ~a_err & ~rst)
      for (int i = 0; i < 8; i++)
        if (a_wmask[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_ysyx_22040237_dmem_rsp.sv
// tb_ysyx_22040237_dmem_rsp: two responders (LAT 2 and 3) checked against a transaction-level model plus directed literals
module tb_ysyx_22040237_dmem_rsp;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst [2] = '{1'b0, 1'b0};
  logic req_valid [2], req_ready [2], req_wen [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [63:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [7:0] req_wmask [2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // An access faults when its byte offset from BASE (mod 2^64) lies beyond the array.
  function automatic bit bad(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    bad = o >= 64'(DEPTH * 8);
`ifdef YSYX_22040237_DMEM_MISALIGN_CHK_EN
    if (a[2:0] != 3'd0) bad = 1'b1;
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int L = (g == 0) ? 2 : 3;
    ysyx_22040237_dmem_rsp #(.BASE(BASE), .DEPTH(DEPTH), .LAT(L)) dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wen(req_wen[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]));

    logic [63:0] m [logic [63:0]];
    bit busy = 0;
    int age = 0;
    logic mw, ee;
    logic [63:0] ma, md, er;
    logic [7:0] mk;

    task automatic apply();
      logic [63:0] ix;
      ix = (ma - BASE) >> 3;
      ee = bad(ma);
      if (!ee && mw)
        for (int i = 0; i < 8; i++)
          if (mk[i]) m[ix][8*i +: 8] = md[8*i +: 8];
      er = (ee || mw) ? 64'd0 : m[ix];
    endtask

    initial forever begin
      @(posedge clk);
      if (rst[g] === 1'b1) busy = 0;
      else if (busy) begin
        if (age >= L && rsp_ready[g] === 1'b1) busy = 0;
        else begin
          age++;
          if (age == L) apply();
        end
      end else if (req_valid[g] === 1'b1) begin
        busy = 1;
        age = 1;
        mw = req_wen[g];
        ma = req_addr[g];
        md = req_wdata[g];
        mk = req_wmask[g];
        if (age == L) apply();
      end
    end

    initial forever begin
      @(negedge clk);
      #1;
      if (rst[g] === 1'b1) begin
        chk($sformatf("ch%0d_rst_ready", g), req_ready[g], 1);
        chk($sformatf("ch%0d_rst_valid", g), rsp_valid[g], 0);
        chk($sformatf("ch%0d_rst_rdata", g), rsp_rdata[g], 0);
        chk($sformatf("ch%0d_rst_err", g), rsp_err[g], 0);
      end else begin
        chk($sformatf("ch%0d_ready", g), req_ready[g], 64'(!busy));
        chk($sformatf("ch%0d_valid", g), rsp_valid[g], 64'(busy && age >= L));
        if (busy && age >= L) begin
          chk($sformatf("ch%0d_rdata", g), rsp_rdata[g], er);
          chk($sformatf("ch%0d_err", g), rsp_err[g], 64'(ee));
        end
      end
    end
  end

  // One request/response exchange, entered and left just after a falling edge.
  task automatic txn(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd,
                     input logic [7:0] k, input int hold,
                     output logic [63:0] rd, output logic e, output int lat);
    int t = 0;
    while (req_ready[d] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("idle_wait", 64'(t < 20), 1);
    req_valid[d] = 1'b1; req_wen[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_wmask[d] = k;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0; req_wen[d] = !w; req_addr[d] = a ^ 64'h18; req_wdata[d] = ~wd; req_wmask[d] = ~k;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    rd = rsp_rdata[d];
    e = rsp_err[d];
    if (hold > 0) begin
      req_valid[d] = 1'b1; req_wen[d] = 1'b1; req_addr[d] = a; req_wmask[d] = 8'hFF; req_wdata[d] = ~rd;
      repeat (hold) @(negedge clk);
      chk("hold_ready", req_ready[d], 0);
    end
    chk("hold_valid", rsp_valid[d], 1);
    chk("hold_rdata", rsp_rdata[d], rd);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    chk("resume_ready", req_ready[d], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic e;
    int lat;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_wen[i] = 0; req_addr[i] = 0; req_wdata[i] = 0; req_wmask[i] = 0; rsp_ready[i] = 0;
    end
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("reset_ready", req_ready[0], 1);
    chk("reset_valid", rsp_valid[0], 0);
    chk("reset_rdata", rsp_rdata[0], 0);
    chk("reset_err", rsp_err[0], 0);
    req_valid[0] = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    txn(0, 1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, rd, e, lat);
    chk("st_lat", lat, 2); chk("st_err", e, 0); chk("st_rdata", rd, 0);
    txn(0, 0, 64'h8000_0010, 0, 0, 0, rd, e, lat);
    chk("ld_lat", lat, 2); chk("ld_rdata", rd, 64'h1122334455667788); chk("ld_err", e, 0);
    txn(0, 1, 64'h8000_0010, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0, rd, e, lat);
    txn(0, 0, 64'h8000_0010, 0, 0, 0, rd, e, lat);
    chk("mask_rdata", rd, 64'h11223344_BBBBBBBB);
    txn(0, 0, 64'h7FFF_FFF8, 0, 0, 0, rd, e, lat);
    chk("low_err", e, 1); chk("low_rdata", rd, 0); chk("low_lat", lat, 2);
    txn(0, 0, 64'h8000_0800, 0, 0, 0, rd, e, lat);
    chk("high_err", e, 1); chk("high_rdata", rd, 0);
    txn(0, 1, 64'h8000_0800, 64'hDEAD, 8'hFF, 0, rd, e, lat);
    chk("high_st_err", e, 1);
    txn(0, 1, 64'h7FFF_FFF8, 64'hBEEF, 8'hFF, 0, rd, e, lat);
    chk("low_st_err", e, 1);
    txn(0, 1, 64'h8000_07F8, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, rd, e, lat);
    chk("last_st_err", e, 0);
    txn(0, 0, 64'h8000_07F8, 0, 0, 0, rd, e, lat);
    chk("last_rdata", rd, 64'h0F0E0D0C0B0A0908); chk("last_err", e, 0);
    txn(0, 1, 64'h8000_0010, 64'h0, 8'h00, 0, rd, e, lat);
    chk("nomask_err", e, 0);
    txn(0, 0, 64'h8000_0010, 0, 0, 5, rd, e, lat);
    chk("hold_word", rd, 64'h11223344_BBBBBBBB);
    txn(0, 0, 64'h8000_0010, 0, 0, 0, rd, e, lat);
    chk("after_hold", rd, 64'h11223344_BBBBBBBB);
    txn(0, 1, 64'h8000_0000, 64'hCAFEBABE_DEADBEEF, 8'hFF, 0, rd, e, lat);
    txn(0, 0, 64'h8000_0004, 0, 0, 0, rd, e, lat);
`ifdef YSYX_22040237_DMEM_MISALIGN_CHK_EN
    chk("mis_err", e, 1); chk("mis_rdata", rd, 0);
`else
    chk("mis_err", e, 0); chk("mis_rdata", rd, 64'hCAFEBABE_DEADBEEF);
`endif
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 64'h8000_0018;
    req_wdata[0] = 64'h5555_6666_7777_8888; req_wmask[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("resp_rst_pre", rsp_valid[0], 1);
    rst[0] = 1'b1;
    #1;
    chk("resp_rst_valid", rsp_valid[0], 0);
    chk("resp_rst_ready", req_ready[0], 1);
    @(negedge clk);
    rst[0] = 1'b0;
    txn(0, 0, 64'h8000_0018, 0, 0, 0, rd, e, lat);
    chk("resp_rst_commit", rd, 64'h5555_6666_7777_8888);
    txn(1, 1, 64'h8000_0020, 64'h0123456789ABCDEF, 8'hFF, 0, rd, e, lat);
    chk("l3_st_lat", lat, 3);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 64'h8000_0020;
    req_wdata[1] = 64'hFFFF_0000_FFFF_0000; req_wmask[1] = 8'hFF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    #1;
    chk("wait_rst_ready", req_ready[1], 1);
    chk("wait_rst_valid", rsp_valid[1], 0);
    chk("wait_rst_rdata", rsp_rdata[1], 0);
    chk("wait_rst_err", rsp_err[1], 0);
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    txn(1, 0, 64'h8000_0020, 0, 0, 0, rd, e, lat);
    chk("l3_ld_lat", lat, 3);
    chk("wait_rst_old", rd, 64'h0123456789ABCDEF);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
